// File: rtl/wb_mem_slave.sv
// Wishbone classic single-port memory slave: byte strobes, programmable wait states, one ack per access.
// Optional out-of-range error response (wb_err) when WB_MEM_ERR_EN is defined.
module wb_mem_slave #(
    parameter int                    addr_width   = 32,
    parameter int                    data_width   = 32,
    parameter int                    strobe_width = data_width / 8,
    parameter int                    depth_words  = 1024,
    parameter int                    wait_states  = 1,
    parameter logic [addr_width-1:0] base_addr    = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [addr_width-1:0]   wb_adr,
    input  logic [data_width-1:0]   wb_datwr,
    output logic [data_width-1:0]   wb_datrd,
    input  logic                    wb_we,
    input  logic                    wb_stb,
    input  logic                    wb_cyc,
    input  logic [strobe_width-1:0] wb_sel,
`ifdef WB_MEM_ERR_EN
    output logic                    wb_err,
`endif
    output logic                    wb_ack
);

    localparam int byte_bits = $clog2(strobe_width);
    localparam int word_bits = $clog2(depth_words);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, next_state;
    logic [3:0]              cnt;
    logic [data_width-1:0]   mem [depth_words];

    logic [word_bits-1:0]    word_q;
    logic                    we_q;
    logic [strobe_width-1:0] sel_q;
    logic [data_width-1:0]   datwr_q;

    logic [addr_width-1:0]   offset;
    logic [word_bits-1:0]    bus_word, cur_word;
    logic                    cur_we;
    logic [strobe_width-1:0] cur_sel;
    logic [data_width-1:0]   cur_datwr;
    logic                    cur_oor;
    logic                    accept, enter_resp, mem_we;
    logic                    unused_bits;

    assign offset      = wb_adr - base_addr;
    assign bus_word    = offset[byte_bits +: word_bits];
    // Byte-offset and above-depth address bits are deliberately ignored.
    assign unused_bits = ^offset;

    // With zero wait states the commit edge is the accept edge, so use the live bus.
    assign cur_word  = (state == IDLE) ? bus_word : word_q;
    assign cur_we    = (state == IDLE) ? wb_we    : we_q;
    assign cur_sel   = (state == IDLE) ? wb_sel   : sel_q;
    assign cur_datwr = (state == IDLE) ? wb_datwr : datwr_q;

`ifdef WB_MEM_ERR_EN
    localparam logic [addr_width:0] span = (addr_width + 1)'(depth_words * strobe_width);
    logic bus_oor, oor_q, err_q;
    assign bus_oor = (wb_adr < base_addr) || ({1'b0, offset} >= span);
    assign cur_oor = (state == IDLE) ? bus_oor : oor_q;
`else
    assign cur_oor = 1'b0;
`endif

    assign accept     = (state == IDLE) && wb_cyc && wb_stb;
    assign enter_resp = (state != RESP) && (next_state == RESP);
    assign mem_we     = enter_resp && cur_we && !cur_oor;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (wb_cyc && wb_stb) next_state = (wait_states > 0) ? WAIT : RESP;
            WAIT:    if (!wb_cyc)          next_state = IDLE;
                     else if (cnt == 4'd1) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        wb_ack = 1'b0;
`ifdef WB_MEM_ERR_EN
        wb_err = 1'b0;
        if (state == RESP) begin
            wb_ack = !err_q;
            wb_err = err_q;
        end
`else
        wb_ack = (state == RESP);
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt      <= '0;
            wb_datrd <= '0;
`ifdef WB_MEM_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            if (accept)              cnt <= 4'(wait_states);
            else if (state == WAIT)  cnt <= cnt - 4'd1;

            if (enter_resp && !cur_we && !cur_oor) wb_datrd <= mem[cur_word];
            else                                   wb_datrd <= '0;
`ifdef WB_MEM_ERR_EN
            if (enter_resp) err_q <= cur_oor;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            word_q  <= bus_word;
            we_q    <= wb_we;
            sel_q   <= wb_sel;
            datwr_q <= wb_datwr;
`ifdef WB_MEM_ERR_EN
            oor_q   <= bus_oor;
`endif
        end
    end

    // NOTE: storage has no reset; contents survive reset and map onto plain RAM.
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            for (int i = 0; i < strobe_width; i++) begin
                if (cur_sel[i]) mem[cur_word][8*i +: 8] <= cur_datwr[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_slave.sv
// Scoreboard bench for wb_mem_slave: four instances with wait_states 0, 1, 3 and 15.
module tb_wb_mem_slave;

    localparam int N = 4;
`ifdef WB_MEM_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   adr, datwr;
    logic          we;
    logic [3:0]    sel;
    logic [N-1:0]  cyc, stb, ack, err;
    logic [31:0]   rdat [N];

    int            checks   = 0;
    int            failures = 0;
    logic [31:0]   model [N][1024];
    logic [31:0]   exp_q [$];

    always #5 clock = ~clock;

    function automatic int ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        wb_mem_slave #(.wait_states(ws_of(g))) dut (
            .clock    (clock),
            .reset    (reset),
            .wb_adr   (adr),
            .wb_datwr (datwr),
            .wb_datrd (rdat[g]),
            .wb_we    (we),
            .wb_stb   (stb[g]),
            .wb_cyc   (cyc[g]),
            .wb_sel   (sel),
`ifdef WB_MEM_ERR_EN
            .wb_err   (err[g]),
`endif
            .wb_ack   (ack[g])
        );
`ifndef WB_MEM_ERR_EN
        assign err[g] = 1'b0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete Wishbone access on instance idx; reads push their expectation to the scoreboard.
    task automatic access(input int idx, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic exp_err, input string tag);
        int          lat;
        logic        got;
        logic [9:0]  word;
        logic [31:0] exp_rd;
        word = a[11:2];
        if (!w) exp_q.push_back(exp_err ? 32'h0 : model[idx][word]);
        else if (!exp_err) begin
            for (int i = 0; i < 4; i++) if (s[i]) model[idx][word][8*i +: 8] = d[8*i +: 8];
        end
        @(negedge clock);
        adr = a; datwr = d; we = w; sel = s; cyc[idx] = 1'b1; stb[idx] = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clock);
            lat++;
            if (ack[idx] || err[idx]) got = 1'b1;
            else check({tag, " datrd before ack"}, rdat[idx], 32'h0);
        end
        cyc[idx] = 1'b0;
        stb[idx] = 1'b0;
        if (!got) begin
            check({tag, " response timeout"}, 32'(lat), 32'(ws_of(idx) + 1));
            if (!w) exp_rd = exp_q.pop_front();
            return;
        end
        check({tag, " latency"}, 32'(lat), 32'(ws_of(idx) + 1));
        check({tag, " ack"}, 32'(ack[idx]), 32'(!exp_err));
        check({tag, " err"}, 32'(err[idx]), 32'(exp_err));
        if (!w) begin
            exp_rd = exp_q.pop_front();
            check({tag, " rdata"}, rdat[idx], exp_rd);
        end
        @(negedge clock);
        check({tag, " single response"}, 32'({ack[idx], err[idx]}), 32'h0);
        check({tag, " datrd after ack"}, rdat[idx], 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        adr = '0; datwr = '0; we = 1'b0; sel = '0; cyc = '0; stb = '0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset ack[%0d]", i), 32'(ack[i]), 32'h0);
            check($sformatf("reset datrd[%0d]", i), rdat[i], 32'h0);
        end
        reset = 1'b1;

        // Basic write/read, wait_states=1.
        access(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "t1 write");
        access(1, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, "t1 read");

        // Byte strobes: sel ignored on read.
        access(1, 1'b1, 32'h20, 32'h11223344, 4'hF,    1'b0, "t2 preload");
        access(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, "t2 strobe write");
        access(1, 1'b0, 32'h20, 32'h0,        4'b0001, 1'b0, "t2 read");
        check("t2 model value", model[1][8], 32'h11BB33DD);

        // Latency sweep over 0, 3 and 15 wait states, including misaligned low bits.
        for (int k = 0; k < N; k++) begin
            if (k == 1) continue;
            access(k, 1'b1, 32'h84, 32'h0F0F0000 + 32'(k), 4'hF, 1'b0, $sformatf("t3 ws%0d write", ws_of(k)));
            access(k, 1'b0, 32'h87, 32'h0,                 4'hF, 1'b0, $sformatf("t3 ws%0d read", ws_of(k)));
        end

        // Mixed random traffic on the zero-wait instance.
        for (int i = 0; i < 6; i++)
            access(0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'($urandom_range(1, 15)), 1'b0, "rnd write");
        for (int i = 0; i < 6; i++)
            access(0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 1'b0, "rnd read");

        // Abort during WAIT: the write is dropped and no ack appears.
        access(2, 1'b1, 32'h30, 32'h12345678, 4'hF, 1'b0, "t4 preload");
        @(negedge clock);
        adr = 32'h30; datwr = 32'h55; we = 1'b1; sel = 4'hF; cyc[2] = 1'b1; stb[2] = 1'b1;
        @(negedge clock);
        check("t4 ack in wait", 32'(ack[2]), 32'h0);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("t4 ack after abort", 32'(ack[2]), 32'h0);
        end
        access(2, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, "t4 readback");

        // Reset in the middle of WAIT discards the pending write.
        access(3, 1'b1, 32'h40, 32'hA5A55A5A, 4'hF, 1'b0, "t5 preload");
        @(negedge clock);
        adr = 32'h40; datwr = 32'hFFFF0000; we = 1'b1; sel = 4'hF; cyc[3] = 1'b1; stb[3] = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t5 ack in reset", 32'(ack[3]), 32'h0);
        reset = 1'b1;
        cyc[3] = 1'b0; stb[3] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("t5 ack after reset", 32'(ack[3]), 32'h0);
        end
        access(3, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, "t5 readback");

        // Address 0x1000 is one past the 1024-word window: error or alias to word 0.
        access(1, 1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 1'b0, "t6 word0 write");
        access(1, 1'b1, 32'h1000, 32'h0BADF00D, 4'hF, ERR,  "t6 oor write");
        access(1, 1'b0, 32'h1000, 32'h0,        4'hF, ERR,  "t6 oor read");
        access(1, 1'b0, 32'h0,    32'h0,        4'hF, 1'b0, "t6 word0 read");

        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
- Wishbone classic single-port memory slave; sits directly downstream of the core-side Wishbone arbiter and consumes its merged instruction/data master bus.
- Serves instruction fetches and data loads/stores from internal word-organised storage.
- Applies per-byte write strobes and a configurable number of wait states.
- Returns exactly one acknowledge per accepted access.

Parameters:
- addr_width, 32, byte address width of wb_adr
- data_width, 32, bus and storage word width (multiple of 8)
- strobe_width, data_width/8, number of byte-select lanes
- depth_words, 1024, storage depth in words (power of two)
- wait_states, 1, extra cycles inserted between request accept and ack (0..15)
- base_addr, 0, byte address mapped to word 0

Ports:
- clock  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- wb_adr  input  addr_width  byte address from master
- wb_datwr  input  data_width  write data
- wb_datrd  output  data_width  read data, valid only while wb_ack=1
- wb_we  input  1  1=write, 0=read
- wb_stb  input  1  strobe
- wb_cyc  input  1  bus cycle active
- wb_sel  input  strobe_width  byte lane enables, bit i = bits [8i+7:8i]
- wb_ack  output  1  single-cycle acknowledge
- wb_err  output  1  present only with WB_MEM_ERR_EN; single-cycle error response

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset=0 at a clock edge):
  - state=IDLE; wb_ack=0, wb_datrd=0, wb_err=0; wait counter cleared.
  - Storage contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Request accepted on an edge where wb_cyc&&wb_stb.
  - Latch adr, we, sel, datwr; load counter with wait_states.
  - Next state is WAIT if wait_states>0, else RESP.
- WAIT:
  - Counter decrements each cycle; at 1 -> RESP.
  - If wb_cyc=0 at any edge: abort -> IDLE, no write, no ack.
- Entering RESP (same edge):
  - Write: for each sel bit set, write the latched byte to mem[word]; lanes with sel=0 keep their old value.
  - Read: register mem[word] into wb_datrd.
  - Raise wb_ack.
  - sel is ignored for reads (full word returned).
- RESP:
  - wb_ack=1 for exactly this cycle, then -> IDLE unconditionally.
  - wb_datrd returns to 0 after this cycle.
  - A stb held high during RESP is not re-accepted until IDLE.
  - Back-to-back access period = wait_states+2 cycles.
- Latency: accept edge to ack-visible cycle = wait_states+1 clock cycles.
- Address mapping:
  - word = (wb_adr - base_addr) >> log2(strobe_width), truncated to log2(depth_words) bits.
  - Low byte-offset bits are ignored (no misaligned support).
  - Without the optional feature, out-of-range addresses wrap modulo depth.
- Write-then-read of the same word in consecutive accesses returns the newly written data.
- wb_cyc=1 with wb_stb=0 in IDLE: no action.
- Reset asserted in WAIT or RESP:
  - Pending write is discarded if not yet committed; ack suppressed.
  - Next cycle is IDLE.
- No simultaneous ack and err ever.

Optional Feature:
- Macro: WB_MEM_ERR_EN.
- Defined:
  - Port wb_err exists.
  - An access with wb_adr < base_addr or wb_adr >= base_addr + depth_words*strobe_width completes through the same WAIT timing.
  - In RESP it asserts wb_err=1 instead of wb_ack, performs no write and drives wb_datrd=0.
- Undefined:
  - No wb_err port; out-of-range addresses wrap as above and always ack.

Test Plan:
1. wait_states=1, base_addr=0: write adr=0x10, datwr=0xDEADBEEF, sel=4'hF, then read 0x10 -> ack 2 cycles after each accept, read returns 0xDEADBEEF, wb_datrd=0 outside the ack cycle.
2. Byte strobes: preload 0x11223344 at 0x20, then write 0xAABBCCDD with sel=4'b0101 -> read returns 0x11BB33DD.
3. Latency sweep over wait_states=0,3,15 -> ack observed exactly 1, 4 and 16 cycles after the accept edge; exactly one ack per access.
4. Abort: wait_states=3, write 0x55 to 0x30, drop wb_cyc after 1 wait cycle -> no ack; subsequent read of 0x30 returns the prior value.
5. Reset mid-WAIT: assert reset=0 during WAIT -> wb_ack stays 0, FSM in IDLE next cycle, a new read is accepted normally.
6. WB_MEM_ERR_EN, depth_words=1024: access adr=0x1000 -> wb_err pulses for 1 cycle, wb_ack=0, no write. Without the macro, the same access aliases word 0 and acks.
